// File: rtl/aes444_pkg.sv
// Shared types, constants and GF(2^4) helpers for the masked small-scale AES-444 decryptor.
// Nibble i = row (i % 4), column (i / 4), stored at bits [4*(15-i) +: 4] (nibble 0 is the MSB).
package aes444_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        KEXP  = 3'd1,
        INIT  = 3'd2,
        ROUND = 3'd3,
        DONE  = 3'd4
    } dec_state_t;

    // Forward S-box is L(x^-1) ^ SBOX_C; the inverse S-box input affine is M(y) ^ INV_AFF_C, M = L^-1.
    localparam logic [3:0] SBOX_C    = 4'h6;
    localparam logic [3:0] INV_AFF_C = 4'h3;

    localparam logic [3:0] RCON [0:9] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3,
                                          4'h6, 4'hC, 4'hB, 4'h5, 4'hA};

    function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[2:0], 1'b0} ^ (aa[3] ? 4'h3 : 4'h0);
        end
        return p;
    endfunction

    function automatic logic [3:0] gf_sq(input logic [3:0] x);
        return gmul(x, x);
    endfunction

    function automatic logic [3:0] mul2(input logic [3:0] x); return gmul(x, 4'h2); endfunction
    function automatic logic [3:0] mul9(input logic [3:0] x); return gmul(x, 4'h9); endfunction
    function automatic logic [3:0] mulb(input logic [3:0] x); return gmul(x, 4'hB); endfunction
    function automatic logic [3:0] muld(input logic [3:0] x); return gmul(x, 4'hD); endfunction
    function automatic logic [3:0] mule(input logic [3:0] x); return gmul(x, 4'hE); endfunction

    function automatic logic [3:0] aff_l(input logic [3:0] x);
        return ({4{x[0]}} & 4'hD) ^ ({4{x[1]}} & 4'hB) ^ ({4{x[2]}} & 4'h7) ^ ({4{x[3]}} & 4'hE);
    endfunction

    function automatic logic [3:0] aff_m(input logic [3:0] x);
        return ({4{x[0]}} & 4'h7) ^ ({4{x[1]}} & 4'hE) ^ ({4{x[2]}} & 4'hD) ^ ({4{x[3]}} & 4'hB);
    endfunction

    function automatic int nib_idx(input int r, input int c);
        return 4 * c + r;
    endfunction

    function automatic logic [3:0] get_nib(input logic [63:0] s, input int i);
        return s[4*(15-i) +: 4];
    endfunction

    function automatic logic [63:0] set_nib(input logic [63:0] s, input int i, input logic [3:0] v);
        logic [63:0] o;
        o = s;
        o[4*(15-i) +: 4] = v;
        return o;
    endfunction

    function automatic logic [63:0] inv_shift_rows(input logic [63:0] s);
        logic [63:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o = set_nib(o, nib_idx(r, c), get_nib(s, nib_idx(r, (c - r + 4) % 4)));
        return o;
    endfunction

    function automatic logic [63:0] inv_mix_columns(input logic [63:0] s);
        logic [63:0] o;
        logic [3:0]  a [4];
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = get_nib(s, nib_idx(r, c));
            for (int r = 0; r < 4; r++)
                o = set_nib(o, nib_idx(r, c), mule(a[r]) ^ mulb(a[(r+1)%4]) ^
                                              muld(a[(r+2)%4]) ^ mul9(a[(r+3)%4]));
        end
        return o;
    endfunction

    function automatic logic [15:0] rot_word(input logic [15:0] w);
        return {w[11:0], w[15:12]};
    endfunction

    // K_r -> K_r+1; t is the S-box/rcon word derived from RotWord(w3).
    function automatic logic [63:0] key_fwd(input logic [63:0] k, input logic [15:0] t);
        logic [15:0] w0, w1, w2, w3;
        w0 = k[63:48] ^ t;
        w1 = k[47:32] ^ w0;
        w2 = k[31:16] ^ w1;
        w3 = k[15:0]  ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // K_r+1 -> K_r; t is derived from RotWord(w3 ^ w2) of the incoming key.
    function automatic logic [63:0] key_inv(input logic [63:0] k, input logic [15:0] t);
        logic [15:0] w0, w1, w2, w3;
        w3 = k[15:0]  ^ k[31:16];
        w2 = k[31:16] ^ k[47:32];
        w1 = k[47:32] ^ k[63:48];
        w0 = k[63:48] ^ t;
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes444_dom_inv_sbox4.sv
// Two-share DOM GF(2^4) inverter (x^14 = x^3^4 * x^2) with 2-cycle latency; FWD=1 gives the forward S-box.
// The random nibble is consumed at stage 1 and carried forward as the stage-2 cross-term refresh.
import aes444_pkg::*;

module dom_inv_sbox4 #(
    parameter bit FWD = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] a0,
    input  logic [3:0] a1,
    input  logic [3:0] z,
    output logic [3:0] y0,
    output logic [3:0] y1
);
    logic [3:0] x0, x1, x20, x21;
    logic [3:0] p00, p01, p10, p11, x2r0, x2r1, zr;
    logic [3:0] c0, c1;
    logic [3:0] q00, q01, q10, q11;
    logic [3:0] v0, v1;

    assign x0  = FWD ? a0 : (aff_m(a0) ^ INV_AFF_C);
    assign x1  = FWD ? a1 : aff_m(a1);
    assign x20 = gf_sq(x0);
    assign x21 = gf_sq(x1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p00 <= '0; p01 <= '0; p10 <= '0; p11 <= '0;
            x2r0 <= '0; x2r1 <= '0; zr <= '0;
        end else begin
            p00  <= gmul(x0, x20);
            p01  <= gmul(x0, x21) ^ z;
            p10  <= gmul(x1, x20) ^ z;
            p11  <= gmul(x1, x21);
            x2r0 <= x20;
            x2r1 <= x21;
            zr   <= z;
        end
    end

    // Shares of x^12, computed from the recombined-per-domain x^3 shares.
    assign c0 = gf_sq(gf_sq(p00 ^ p01));
    assign c1 = gf_sq(gf_sq(p11 ^ p10));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q00 <= '0; q01 <= '0; q10 <= '0; q11 <= '0;
        end else begin
            q00 <= gmul(c0, x2r0);
            q01 <= gmul(c0, x2r1) ^ zr;
            q10 <= gmul(c1, x2r0) ^ zr;
            q11 <= gmul(c1, x2r1);
        end
    end

    assign v0 = q00 ^ q01;
    assign v1 = q11 ^ q10;
    assign y0 = FWD ? (aff_l(v0) ^ SBOX_C) : v0;
    assign y1 = FWD ? aff_l(v1) : v1;

endmodule

// File: rtl/aes444_dec.sv
// Iterative first-order DOM-masked AES-444 decryptor; shares recombine only into text_out.
// Handshake: start is a one-cycle request honoured only in IDLE; done pulses once per run, busy covers the run.
import aes444_pkg::*;

module aes444_dec (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] key_in,
    input  logic [63:0] k_mask,
    input  logic [63:0] text_in,
    input  logic [63:0] t_mask,
    input  logic [79:0] r_bits,
    output logic [63:0] text_out,
    output logic        done,
    output logic        busy,
    output logic [2:0]  dbg_state
);
    dec_state_t  state;
    logic [1:0]  ph;
    logic [3:0]  rnd;
    logic [63:0] s0, s1, k0, k1;
    logic [63:0] isr0, isr1, sb0, sb1;
    logic [63:0] kn0, kn1, ark0, ark1;
    logic [15:0] kin0, kin1, ks0, ks1, rc_word;

    assign isr0    = inv_shift_rows(s0);
    assign isr1    = inv_shift_rows(s1);
    assign kin0    = (state == ROUND) ? rot_word(k0[15:0] ^ k0[31:16]) : rot_word(k0[15:0]);
    assign kin1    = (state == ROUND) ? rot_word(k1[15:0] ^ k1[31:16]) : rot_word(k1[15:0]);
    assign rc_word = {RCON[rnd], 12'h000};

    // Only share 0 carries the round constant.
    always_comb begin
        kn0 = key_inv(k0, ks0 ^ rc_word);
        kn1 = key_inv(k1, ks1);
        if (state == KEXP) begin
            kn0 = key_fwd(k0, ks0 ^ rc_word);
            kn1 = key_fwd(k1, ks1);
        end
    end

    assign ark0 = sb0 ^ kn0;
    assign ark1 = sb1 ^ kn1;

    for (genvar i = 0; i < 16; i++) begin : g_state_sbox
        dom_inv_sbox4 #(.FWD(1'b0)) u_sbox (
            .clk (clk),
            .rst (rst),
            .a0  (isr0[4*(15-i) +: 4]),
            .a1  (isr1[4*(15-i) +: 4]),
            .z   (r_bits[4*i +: 4]),
            .y0  (sb0[4*(15-i) +: 4]),
            .y1  (sb1[4*(15-i) +: 4])
        );
    end

    for (genvar j = 0; j < 4; j++) begin : g_key_sbox
        dom_inv_sbox4 #(.FWD(1'b1)) u_sbox (
            .clk (clk),
            .rst (rst),
            .a0  (kin0[4*(3-j) +: 4]),
            .a1  (kin1[4*(3-j) +: 4]),
            .z   (r_bits[64 + 4*j +: 4]),
            .y0  (ks0[4*(3-j) +: 4]),
            .y1  (ks1[4*(3-j) +: 4])
        );
    end

    // Each KEXP step and each ROUND takes 3 cycles: launch, S-box stage 2, commit on ph==2.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ph       <= '0;
            rnd      <= '0;
            s0       <= '0;
            s1       <= '0;
            k0       <= '0;
            k1       <= '0;
            text_out <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        k0    <= key_in;
                        k1    <= k_mask;
                        s0    <= text_in;
                        s1    <= t_mask;
                        ph    <= '0;
                        rnd   <= '0;
                        busy  <= 1'b1;
                        state <= KEXP;
                    end
                end
                KEXP: begin
                    if (ph == 2'd2) begin
                        k0 <= kn0;
                        k1 <= kn1;
                        ph <= '0;
                        if (rnd == 4'd9) state <= INIT;
                        else             rnd   <= rnd + 4'd1;
                    end else begin
                        ph <= ph + 2'd1;
                    end
                end
                INIT: begin
                    s0    <= s0 ^ k0;
                    s1    <= s1 ^ k1;
                    rnd   <= 4'd9;
                    ph    <= '0;
                    state <= ROUND;
                end
                ROUND: begin
                    if (ph == 2'd2) begin
                        k0 <= kn0;
                        k1 <= kn1;
                        s0 <= (rnd == 4'd0) ? ark0 : inv_mix_columns(ark0);
                        s1 <= (rnd == 4'd0) ? ark1 : inv_mix_columns(ark1);
                        ph <= '0;
                        if (rnd == 4'd0) state <= DONE;
                        else             rnd   <= rnd - 4'd1;
                    end else begin
                        ph <= ph + 2'd1;
                    end
                end
                DONE: begin
                    // First DONE cycle writes the output; the FSM stays here while done is high.
                    if (!done) begin
                        text_out <= s0 ^ s1;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_aes444_dec.sv
// Directed bench for aes444_dec: ciphertexts come from an independent table-driven AES-444 encryptor.
module tb_aes444_dec;

    logic        clk;
    logic        rst;
    logic        start;
    logic [63:0] key_in, k_mask, text_in, t_mask;
    logic [79:0] r_bits;
    logic [63:0] text_out;
    logic        done, busy;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    int r_mode = 2;

    aes444_dec dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_in    (key_in),
        .k_mask    (k_mask),
        .text_in   (text_in),
        .t_mask    (t_mask),
        .r_bits    (r_bits),
        .text_out  (text_out),
        .done      (done),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // randomness driver: 0 = all zero, 1 = all ones, otherwise fresh every cycle
    initial begin
        r_bits = '0;
        forever begin
            @(negedge clk);
            case (r_mode)
                0:       r_bits = '0;
                1:       r_bits = '1;
                default: r_bits = {16'($urandom), $urandom, $urandom};
            endcase
        end
    end

    // reference encryptor
    function automatic logic [3:0] b_sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h6; 4'h1: y = 4'hB; 4'h2: y = 4'h5; 4'h3: y = 4'h4;
            4'h4: y = 4'h2; 4'h5: y = 4'hE; 4'h6: y = 4'h7; 4'h7: y = 4'hA;
            4'h8: y = 4'h9; 4'h9: y = 4'hD; 4'hA: y = 4'hF; 4'hB: y = 4'hC;
            4'hC: y = 4'h3; 4'hD: y = 4'h1; 4'hE: y = 4'h0; default: y = 4'h8;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] b_gmul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p, aa;
        p = '0; aa = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[2:0], 1'b0} ^ (aa[3] ? 4'h3 : 4'h0);
        end
        return p;
    endfunction

    function automatic logic [3:0] b_nib(input logic [63:0] s, input int r, input int c);
        return s[4*(15-(4*c+r)) +: 4];
    endfunction

    function automatic logic [63:0] b_round(input logic [63:0] s, input bit mix);
        logic [63:0] sh, o;
        logic [3:0]  a [4];
        sh = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sh[4*(15-(4*c+r)) +: 4] = b_sbox(b_nib(s, r, (c + r) % 4));
        if (!mix) return sh;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = b_nib(sh, r, c);
            for (int r = 0; r < 4; r++)
                o[4*(15-(4*c+r)) +: 4] = b_gmul(a[r], 4'h2) ^ b_gmul(a[(r+1)%4], 4'h3)
                                         ^ a[(r+2)%4] ^ a[(r+3)%4];
        end
        return o;
    endfunction

    function automatic logic [63:0] b_key_next(input logic [63:0] k, input int r);
        logic [3:0]  rc;
        logic [15:0] w3, t, w0, w1, w2;
        rc = 4'h1;
        for (int i = 0; i < r; i++) rc = b_gmul(rc, 4'h2);
        w3 = k[15:0];
        t  = {b_sbox(w3[11:8]) ^ rc, b_sbox(w3[7:4]), b_sbox(w3[3:0]), b_sbox(w3[15:12])};
        w0 = k[63:48] ^ t;
        w1 = k[47:32] ^ w0;
        w2 = k[31:16] ^ w1;
        return {w0, w1, w2, k[15:0] ^ w2};
    endfunction

    function automatic logic [63:0] b_encrypt(input logic [63:0] key, input logic [63:0] pt);
        logic [63:0] s, k;
        k = key;
        s = pt ^ k;
        for (int r = 0; r < 10; r++) begin
            s = b_round(s, r < 9);
            k = b_key_next(k, r);
            s = s ^ k;
        end
        return s;
    endfunction

    // scoreboard
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // driver: one decryption; poke re-pulses start so it is sampled at edges 10 and 62
    task automatic run_dec(input logic [63:0] key, input logic [63:0] km, input logic [63:0] ct,
                           input logic [63:0] tm, input bit poke,
                           output logic [63:0] pt, output int lat, output int busy_hi);
        int cnt;
        @(negedge clk);
        key_in  = key ^ km;
        k_mask  = km;
        text_in = ct ^ tm;
        t_mask  = tm;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        cnt     = 0;
        lat     = -1;
        busy_hi = busy ? 1 : 0;
        while (cnt < 200 && lat < 0) begin
            if (poke && (cnt == 9 || cnt == 61)) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            cnt++;
            if (done) lat = cnt;
            else if (busy) busy_hi++;
        end
        pt = text_out;
    endtask

    localparam logic [63:0] KEY1 = 64'hFEDCBA9876543210;
    localparam logic [63:0] PT2  = 64'h0123456789ABCDEF;

    initial begin
        logic [63:0] ct1, ct2, pt, key, ptr, ctr;
        int lat, bh, extra;

        rst = 1'b0; start = 1'b0;
        key_in = '0; k_mask = '0; text_in = '0; t_mask = '0;
        repeat (3) @(negedge clk);
        chk("reset_text_out", text_out, 64'h0);
        chk("reset_done", 64'(done), 64'h0);
        chk("reset_busy", 64'(busy), 64'h0);
        chk("reset_state", 64'(dbg_state), 64'h0);
        rst = 1'b1;

        ct1 = b_encrypt(KEY1, 64'h0);
        ct2 = b_encrypt(64'h0, PT2);

        // round trip with the reference masks, latency and busy length
        r_mode = 2;
        run_dec(KEY1, 64'h6865498b823f27f8, ct1, 64'hcf262e324a00edca, 1'b0, pt, lat, bh);
        chk("rt_plain", pt, 64'h0);
        chk("rt_latency", 64'(lat), 64'd62);
        chk("rt_busy_cycles", 64'(bh), 64'd62);

        // mask independence
        run_dec(KEY1, 64'h0, ct1, 64'h0, 1'b0, pt, lat, bh);
        chk("mask_zero", pt, 64'h0);
        run_dec(KEY1, '1, ct1, '1, 1'b0, pt, lat, bh);
        chk("mask_ones", pt, 64'h0);
        run_dec(KEY1, {$urandom, $urandom}, ct1, {$urandom, $urandom}, 1'b0, pt, lat, bh);
        chk("mask_rand", pt, 64'h0);

        // randomness independence
        r_mode = 0;
        run_dec(KEY1, {$urandom, $urandom}, ct1, {$urandom, $urandom}, 1'b0, pt, lat, bh);
        chk("rbits_zero", pt, 64'h0);
        r_mode = 1;
        run_dec(KEY1, {$urandom, $urandom}, ct1, {$urandom, $urandom}, 1'b0, pt, lat, bh);
        chk("rbits_ones", pt, 64'h0);
        r_mode = 2;
        run_dec(KEY1, {$urandom, $urandom}, ct1, {$urandom, $urandom}, 1'b0, pt, lat, bh);
        chk("rbits_rand", pt, 64'h0);

        // nonzero plaintext, zero key
        run_dec(64'h0, {$urandom, $urandom}, ct2, {$urandom, $urandom}, 1'b0, pt, lat, bh);
        chk("pt2_plain", pt, PT2);

        // start during busy and in DONE is ignored
        run_dec(KEY1, {$urandom, $urandom}, ct1, {$urandom, $urandom}, 1'b1, pt, lat, bh);
        chk("poke_plain", pt, 64'h0);
        chk("poke_latency", 64'(lat), 64'd62);
        chk("poke_busy_cycles", 64'(bh), 64'd62);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_in_done_ignored", 64'(busy), 64'h0);
        extra = 0;
        repeat (70) begin
            @(negedge clk);
            if (done) extra++;
        end
        chk("single_done", 64'(extra), 64'h0);

        // back-to-back: second start sampled the cycle after done
        run_dec(KEY1, {$urandom, $urandom}, ct1, {$urandom, $urandom}, 1'b0, pt, lat, bh);
        chk("b2b_first", pt, 64'h0);
        run_dec(64'h0, {$urandom, $urandom}, ct2, {$urandom, $urandom}, 1'b0, pt, lat, bh);
        chk("b2b_second", pt, PT2);
        chk("b2b_latency", 64'(lat), 64'd62);

        // reset in the middle of a run
        @(negedge clk);
        key_in = KEY1; k_mask = '0; text_in = ct1; t_mask = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'h0);
        chk("midrst_done", 64'(done), 64'h0);
        chk("midrst_text_out", text_out, 64'h0);
        chk("midrst_state", 64'(dbg_state), 64'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        run_dec(64'h0, {$urandom, $urandom}, ct2, {$urandom, $urandom}, 1'b0, pt, lat, bh);
        chk("after_rst_plain", pt, PT2);
        chk("after_rst_latency", 64'(lat), 64'd62);

        // random key/plaintext pairs with random masks
        for (int n = 0; n < 1000; n++) begin
            key = {$urandom, $urandom};
            ptr = {$urandom, $urandom};
            ctr = b_encrypt(key, ptr);
            run_dec(key, {$urandom, $urandom}, ctr, {$urandom, $urandom}, 1'b0, pt, lat, bh);
            chk("random_pair", pt, ptr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
